// File: rtl/step_decoder_pkg.sv
// Shared definitions for the step decoder: opcodes, phase indices, micro-op
// bit positions, SEQTYPE codes, checker state encodings and small decode helpers.
package step_decoder_pkg;

  localparam int MAX_EXEC_DEF = 6;

  // Phase vector layout used by every {CK_*} / {STB_*} bundle.
  localparam int NPH      = 10;
  localparam int PH_FETCH = 0;
  localparam int PH_AUTO1 = 1;
  localparam int PH_AUTO2 = 2;
  localparam int PH_IND   = 3;
  localparam int PH_EX1   = 4;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam logic [1:0] SEQ_DIRECT = 2'b00;
  localparam logic [1:0] SEQ_IND    = 2'b01;
  localparam logic [1:0] SEQ_PPIND  = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_AUTO1 = 3'd2;
  localparam logic [2:0] S_AUTO2 = 3'd3;
  localparam logic [2:0] S_IND   = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;

  localparam int U_MA_LD   = 0;
  localparam int U_MEM_RD  = 1;
  localparam int U_MEM_WE  = 2;
  localparam int U_AC_LD   = 3;
  localparam int U_AC_CLR  = 4;
  localparam int U_PC_LD   = 5;
  localparam int U_PC_INC  = 6;
  localparam int U_ALU_AND = 7;
  localparam int U_ALU_ADD = 8;
  localparam int U_MD_INC  = 9;
  localparam int U_LINK_LD = 10;
  localparam int U_IR_LD   = 11;
  localparam int U_IOT_EN  = 12;
  localparam int U_OPR_EN  = 13;
  localparam int U_AUTO_EN = 14;
  localparam int U_IND_EN  = 15;

  function automatic logic [2:0] exec_count(input logic [2:0] op);
    case (op)
      OP_AND, OP_TAD, OP_DCA, OP_JMS: return 3'd2;
      OP_ISZ, OP_OPR:                 return 3'd3;
      default:                        return 3'd1;
    endcase
  endfunction

  // hi = word[11:3]: opcode in [8:6], indirect bit in [5], page/offset in [4:0].
  function automatic logic [1:0] seq_of(input logic [8:0] hi);
    if (hi[8:6] == OP_IOT || hi[8:6] == OP_OPR || !hi[5]) return SEQ_DIRECT;
    else if (hi[4:0] == 5'b00001)                         return SEQ_PPIND;
    else                                                  return SEQ_IND;
  endfunction

endpackage

// File: rtl/step_checker.sv
// Phase-ordering FSM: follows the sequencer's strobes, tracks the execute
// phase number and raises a sticky error on any protocol violation.
module step_checker
  import step_decoder_pkg::*;
#(
  parameter int MAX_EXEC = MAX_EXEC_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NPH-1:0] i_ck,
  input  logic [NPH-1:0] i_stb,
  input  logic [1:0]     i_seqtype,
  input  logic           i_done,
  output logic           o_err,
  output logic [2:0]     o_state,
  output logic [2:0]     o_ph
);

  logic [2:0] r_state;
  logic [2:0] r_ph;
  logic       r_err;

  logic       w_any_stb;
  logic       w_multi_ck;
  logic       w_orphan;
  logic       w_order_err;
  logic       w_max_err;
  logic [3:0] w_obs;
  logic [3:0] w_exp;
  logic [2:0] w_ex_n;
  logic [2:0] w_nxt_state;
  logic [2:0] w_nxt_ph;

  always_comb begin
    w_any_stb  = |i_stb;
    w_multi_ck = (i_ck & (i_ck - 10'd1)) != '0;
    w_orphan   = |(i_stb & ~i_ck);

    // Lowest-numbered strobe wins if several fire together.
    w_obs = '0;
    for (int k = NPH - 1; k >= 0; k--) begin
      if (i_stb[k]) w_obs = 4'(k);
    end

    case (r_state)
      S_AUTO1: w_exp = 4'(PH_AUTO1);
      S_AUTO2: w_exp = 4'(PH_AUTO2);
      S_IND:   w_exp = 4'(PH_IND);
      S_EXEC:  w_exp = 4'(PH_EX1 - 1) + {1'b0, r_ph};
      default: w_exp = 4'(PH_FETCH);
    endcase

    w_ex_n      = 3'(w_obs - 4'(PH_EX1) + 4'd1);
    w_order_err = w_any_stb && (w_obs != w_exp);
    w_max_err   = w_any_stb && (w_obs == 4'(PH_EX1 + MAX_EXEC - 1)) && !i_done;

    // Next state follows the observed phase, so an error resynchronises for free.
    w_nxt_state = r_state;
    w_nxt_ph    = r_ph;
    if (w_any_stb) begin
      if (w_obs == 4'(PH_FETCH)) begin
        case (i_seqtype)
          SEQ_PPIND: begin w_nxt_state = S_AUTO1; w_nxt_ph = 3'd0; end
          SEQ_IND:   begin w_nxt_state = S_IND;   w_nxt_ph = 3'd0; end
          default:   begin w_nxt_state = S_EXEC;  w_nxt_ph = 3'd1; end
        endcase
      end else if (w_obs == 4'(PH_AUTO1)) begin
        w_nxt_state = S_AUTO2;
        w_nxt_ph    = 3'd0;
      end else if (w_obs == 4'(PH_AUTO2)) begin
        w_nxt_state = S_IND;
        w_nxt_ph    = 3'd0;
      end else if (w_obs == 4'(PH_IND)) begin
        w_nxt_state = S_EXEC;
        w_nxt_ph    = 3'd1;
      end else if (i_done || w_obs >= 4'(PH_EX1 + MAX_EXEC - 1)) begin
        w_nxt_state = S_FETCH;
        w_nxt_ph    = 3'd0;
      end else begin
        w_nxt_state = S_EXEC;
        w_nxt_ph    = w_ex_n + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ph    <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ph    <= w_nxt_ph;
      if (w_multi_ck || w_orphan || w_order_err || w_max_err) r_err <= 1'b1;
    end
  end

  assign o_err   = r_err;
  assign o_state = r_state;
  assign o_ph    = r_ph;

endmodule

// File: rtl/step_decoder.sv
// Control-side partner of the step sequencer: latches IR, returns SEQTYPE and
// DONE, decodes per-phase micro-op enables and generates the skip request.
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int MAX_EXEC = MAX_EXEC_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CK_FETCH,
  input  logic        CK_AUTO1,
  input  logic        CK_AUTO2,
  input  logic        CK_IND,
  input  logic        CK_1,
  input  logic        CK_2,
  input  logic        CK_3,
  input  logic        CK_4,
  input  logic        CK_5,
  input  logic        CK_6,
  input  logic        STB_FETCH,
  input  logic        STB_AUTO1,
  input  logic        STB_AUTO2,
  input  logic        STB_IND,
  input  logic        STB_1,
  input  logic        STB_2,
  input  logic        STB_3,
  input  logic        STB_4,
  input  logic        STB_5,
  input  logic        STB_6,
  input  logic [11:0] MD,
  input  logic        MD_ZERO,
  output logic [1:0]  SEQTYPE,
  output logic        DONE,
  output logic [15:0] UOP,
  output logic [11:0] IR,
  output logic        SKIP,
  output logic        ERR,
  output logic [2:0]  DBG_STATE,
  output logic [2:0]  DBG_PH
);

  logic [11:0]    r_ir;
  logic           r_skip;

  logic [NPH-1:0] w_ck;
  logic [NPH-1:0] w_stb;
  logic [8:0]     w_hi;
  logic [1:0]     w_seq;
  logic [2:0]     w_op;
  logic [2:0]     w_nexec;
  logic [5:0]     w_last_mask;
  logic           w_done;
  logic           w_opr_g2;
  logic           w_skip_cond;
  logic [15:0]    w_uop;

  assign w_ck  = {CK_6, CK_5, CK_4, CK_3, CK_2, CK_1, CK_IND, CK_AUTO2, CK_AUTO1, CK_FETCH};
  assign w_stb = {STB_6, STB_5, STB_4, STB_3, STB_2, STB_1,
                  STB_IND, STB_AUTO2, STB_AUTO1, STB_FETCH};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          r_ir <= '0;
    else if (STB_FETCH) r_ir <= MD;
  end

  // Bypass MD during the fetch strobe so the sequencer sees the new route immediately.
  assign w_hi  = STB_FETCH ? MD[11:3] : r_ir[11:3];
  assign w_seq = seq_of(w_hi);

  assign w_op        = r_ir[11:9];
  assign w_nexec     = exec_count(w_op);
  assign w_last_mask = 6'b000001 << (w_nexec - 3'd1);
  assign w_done      = |(w_stb[NPH-1:PH_EX1] & w_last_mask);

  // OPR group 2 reuses the ISZ skip path; the sequencer presents the evaluated
  // skip condition on MD_ZERO.
  assign w_opr_g2    = (w_op == OP_OPR) && r_ir[8] && !r_ir[0];
  assign w_skip_cond = STB_3 && MD_ZERO && ((w_op == OP_ISZ) || w_opr_g2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_skip <= 1'b0;
    else       r_skip <= w_skip_cond;
  end

  // Enables cover the whole CK window; state-changing loads need the strobe too.
  always_comb begin
    w_uop = '0;
    if (CK_FETCH) begin
      w_uop[U_MEM_RD] = 1'b1;
      w_uop[U_PC_INC] = 1'b1;
      w_uop[U_IR_LD]  = STB_FETCH;
    end
    if (CK_AUTO1) begin
      w_uop[U_AUTO_EN] = 1'b1;
      w_uop[U_MEM_RD]  = 1'b1;
      w_uop[U_MD_INC]  = 1'b1;
    end
    if (CK_AUTO2) begin
      w_uop[U_AUTO_EN] = 1'b1;
      w_uop[U_MEM_WE]  = STB_AUTO2;
    end
    if (CK_IND) begin
      w_uop[U_IND_EN] = 1'b1;
      w_uop[U_MEM_RD] = 1'b1;
      w_uop[U_MA_LD]  = 1'b1;
    end
    case (w_op)
      OP_AND, OP_TAD: begin
        if (CK_1) begin
          w_uop[U_MA_LD]  = 1'b1;
          w_uop[U_MEM_RD] = 1'b1;
        end
        if (CK_2) begin
          w_uop[U_ALU_AND] = (w_op == OP_AND);
          w_uop[U_ALU_ADD] = (w_op == OP_TAD);
          w_uop[U_AC_LD]   = STB_2;
          w_uop[U_LINK_LD] = STB_2 && (w_op == OP_TAD);
        end
      end
      OP_ISZ: begin
        if (CK_1) begin
          w_uop[U_MA_LD]  = 1'b1;
          w_uop[U_MEM_RD] = 1'b1;
        end
        if (CK_2) w_uop[U_MD_INC] = 1'b1;
        if (CK_3) w_uop[U_MEM_WE] = STB_3;
      end
      OP_DCA: begin
        if (CK_1) w_uop[U_MA_LD] = 1'b1;
        if (CK_2) begin
          w_uop[U_MEM_WE] = STB_2;
          w_uop[U_AC_CLR] = 1'b1;
        end
      end
      OP_JMS: begin
        if (CK_1) begin
          w_uop[U_MA_LD]  = 1'b1;
          w_uop[U_MEM_WE] = STB_1;
        end
        if (CK_2) w_uop[U_PC_LD] = STB_2;
      end
      OP_JMP: begin
        if (CK_1) w_uop[U_PC_LD] = STB_1;
      end
      OP_IOT: begin
        if (CK_1) w_uop[U_IOT_EN] = 1'b1;
      end
      default: begin
        if (CK_1 || CK_2 || CK_3) w_uop[U_OPR_EN] = 1'b1;
        if (CK_3 && !r_ir[8]) begin
          w_uop[U_AC_LD]   = STB_3;
          w_uop[U_LINK_LD] = STB_3;
        end
      end
    endcase
  end

  step_checker #(
    .MAX_EXEC (MAX_EXEC)
  ) u_checker (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_ck      (w_ck),
    .i_stb     (w_stb),
    .i_seqtype (w_seq),
    .i_done    (w_done),
    .o_err     (ERR),
    .o_state   (DBG_STATE),
    .o_ph      (DBG_PH)
  );

  assign SEQTYPE = RESET ? 2'b00 : w_seq;
  assign DONE    = w_done && !RESET;
  assign UOP     = RESET ? 16'h0000 : w_uop;
  assign IR      = r_ir;
  assign SKIP    = r_skip;

endmodule

// File: tb/tb_step_decoder.sv
// Bench for step_decoder: a sequencer model walks table-driven instructions
// through their phases; hand-written sequences cover errors and mid-reset.
module tb_step_decoder;
  import step_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ck;
  logic [9:0]  stb;
  logic [11:0] md;
  logic        md_zero;
  logic [1:0]  seqtype;
  logic        done;
  logic [15:0] uop;
  logic [11:0] ir;
  logic        skip;
  logic        err;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_ph;

  int n_pass  = 0;
  int n_total = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [11:0] md;
    logic        mz;
    logic [1:0]  seq;
    int          nexec;
    logic        skip;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  step_decoder dut (
    .CLK(clk), .RESET(rst),
    .CK_FETCH(ck[0]), .CK_AUTO1(ck[1]), .CK_AUTO2(ck[2]), .CK_IND(ck[3]),
    .CK_1(ck[4]), .CK_2(ck[5]), .CK_3(ck[6]), .CK_4(ck[7]), .CK_5(ck[8]), .CK_6(ck[9]),
    .STB_FETCH(stb[0]), .STB_AUTO1(stb[1]), .STB_AUTO2(stb[2]), .STB_IND(stb[3]),
    .STB_1(stb[4]), .STB_2(stb[5]), .STB_3(stb[6]), .STB_4(stb[7]), .STB_5(stb[8]),
    .STB_6(stb[9]),
    .MD(md), .MD_ZERO(md_zero),
    .SEQTYPE(seqtype), .DONE(done), .UOP(uop), .IR(ir), .SKIP(skip), .ERR(err),
    .DBG_STATE(dbg_state), .DBG_PH(dbg_ph)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ck  = '0;
    stb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One phase: 2-cycle CK window, strobe in the second cycle, outputs scored there.
  task automatic run_phase(input int p, input logic [11:0] d, input logic exp_done,
                           input logic [1:0] exp_seq);
    logic [2:0] e;
    @(posedge clk); #1;
    ck = '0; ck[p] = 1'b1; stb = '0;
    @(posedge clk); #1;
    stb[p] = 1'b1;
    md = d;
    exp_q.push_back({exp_seq, exp_done});
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("phase%0d seq/done", p), {30'd0, seqtype, done}, {29'd0, e});
    @(posedge clk); #1;
    ck  = '0;
    stb = '0;
  endtask

  task automatic run_instr(input vec_t v);
    md_zero = v.mz;
    run_phase(PH_FETCH, v.md, 1'b0, v.seq);
    check("ir_load", {20'd0, ir}, {20'd0, v.md});
    if (v.seq == 2'b10) begin
      run_phase(PH_AUTO1, 12'($urandom_range(0, 4095)), 1'b0, v.seq);
      run_phase(PH_AUTO2, 12'($urandom_range(0, 4095)), 1'b0, v.seq);
    end
    if (v.seq != 2'b00) run_phase(PH_IND, 12'($urandom_range(0, 4095)), 1'b0, v.seq);
    for (int k = 1; k <= v.nexec; k++)
      run_phase(PH_EX1 + k - 1, 12'($urandom_range(0, 4095)), (k == v.nexec), v.seq);
    @(negedge clk);
    check("skip_pulse", {31'd0, skip}, {31'd0, v.skip});
    @(negedge clk);
    check("skip_clear", {31'd0, skip}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{12'o1234, 1'b0, 2'b00, 2, 1'b0};
    vecs[1]  = '{12'o5410, 1'b0, 2'b10, 1, 1'b0};
    vecs[2]  = '{12'o2500, 1'b1, 2'b01, 3, 1'b1};
    vecs[3]  = '{12'o2100, 1'b0, 2'b00, 3, 1'b0};
    vecs[4]  = '{12'o0377, 1'b1, 2'b00, 2, 1'b0};
    vecs[5]  = '{12'o3412, 1'b0, 2'b10, 2, 1'b0};
    vecs[6]  = '{12'o4600, 1'b0, 2'b01, 2, 1'b0};
    vecs[7]  = '{12'o6410, 1'b1, 2'b00, 1, 1'b0};
    vecs[8]  = '{12'o7410, 1'b1, 2'b00, 3, 1'b1};
    vecs[9]  = '{12'o7200, 1'b1, 2'b00, 3, 1'b0};
    vecs[10] = '{12'o1017, 1'b0, 2'b00, 2, 1'b0};
    vecs[11] = '{12'o1417, 1'b0, 2'b10, 2, 1'b0};
    vecs[12] = '{12'o1420, 1'b0, 2'b01, 2, 1'b0};

    // Reset state, with a fetch strobe of an auto-index word held to prove gating.
    rst = 1'b1; ck = '0; stb = '0; md = 12'o5410; md_zero = 1'b0;
    stb[0] = 1'b1; ck[0] = 1'b1;
    #12;
    check("rst_ir", {20'd0, ir}, 32'd0);
    check("rst_skip", {31'd0, skip}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_seq", {30'd0, seqtype}, 32'd0);
    check("rst_uop", {16'd0, uop}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    do_reset();

    foreach (vecs[i]) run_instr(vecs[i]);
    check("no_err_after_table", {31'd0, err}, 32'd0);

    // STB_2 with no CK window: sticky error.
    do_reset();
    @(posedge clk); #1 stb[5] = 1'b1;
    @(posedge clk); #1 stb = '0;
    @(negedge clk);
    check("orphan_stb_err", {31'd0, err}, 32'd1);
    run_instr(vecs[0]);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // Two CK windows at once.
    @(posedge clk); #1 ck[0] = 1'b1; ck[4] = 1'b1;
    @(posedge clk); #1 ck = '0;
    @(negedge clk);
    check("multi_ck_err", {31'd0, err}, 32'd1);
    do_reset();

    // Auto-index route that skips AUTO1/AUTO2.
    md_zero = 1'b0;
    run_phase(PH_FETCH, 12'o5410, 1'b0, 2'b10);
    check("order_ok_so_far", {31'd0, err}, 32'd0);
    run_phase(PH_IND, 12'o0000, 1'b0, 2'b10);
    @(negedge clk);
    check("order_err", {31'd0, err}, 32'd1);
    do_reset();

    // Mid-instruction reset during CK_2 of TAD.
    run_phase(PH_FETCH, 12'o1234, 1'b0, 2'b00);
    run_phase(PH_EX1, 12'o0000, 1'b0, 2'b00);
    @(posedge clk); #1 ck[5] = 1'b1;
    @(negedge clk);
    check("tad_add_en", {31'd0, uop[U_ALU_ADD]}, 32'd1);
    check("tad_acld_no_stb", {31'd0, uop[U_AC_LD]}, 32'd0);
    @(posedge clk); #1 stb[5] = 1'b1;
    #1;
    check("tad_acld_stb", {31'd0, uop[U_AC_LD]}, 32'd1);
    check("tad_done", {31'd0, done}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_uop", {16'd0, uop}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ir", {20'd0, ir}, 32'd0);
    @(posedge clk); #1 ck = '0; stb = '0;
    @(posedge clk); #1 rst = 1'b0;
    run_instr('{12'o7200, 1'b0, 2'b00, 3, 1'b0});
    check("post_rst_err", {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
